// File: rtl/pcie_scrambler_pkg.sv
// Shared constants and types for the PCIe TX lane scrambler.
package pcie_scrambler_pkg;

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned SYMS   = 4;
  localparam int unsigned DATA_W = SYM_W * SYMS;
  localparam int unsigned LFSR_W = 23;
  localparam int unsigned SEED_W = 24;

  // Galois feedback masks (x^n term implied by the shift-out bit)
  localparam logic [15:0]       POLY16 = 16'h0039;
  localparam logic [LFSR_W-1:0] POLY23 = 23'h210125;
  localparam logic [15:0]       INIT16 = 16'hFFFF;

  localparam logic [SYM_W-1:0] COM_SYM   = 8'hBC;
  localparam logic [SYM_W-1:0] SKP_SYM   = 8'h1C;
  localparam logic [SYM_W-1:0] EIEOS_SYM = 8'h00;
  localparam logic [SYM_W-1:0] SKPOS_SYM = 8'hAA;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  typedef enum logic [1:0] {
    BLK_DATA     = 2'd0,
    BLK_OS_GEN   = 2'd1,
    BLK_OS_EIEOS = 2'd2,
    BLK_OS_SKP   = 2'd3
  } blk_state_t;

  typedef struct packed {
    logic scramble;
    logic advance;
    logic reload;
  } sym_ctl_t;

endpackage

// File: rtl/pcie_scr_lfsr_step.sv
// One-symbol LFSR step: produces the scramble byte and the state after this symbol.
module pcie_scr_lfsr_step
  import pcie_scrambler_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic              gen3,
  input  logic              advance,
  input  logic              reload,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] next_state_c,
  output logic [SYM_W-1:0]  key_c
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s     = state;
    key_c = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (gen3) begin
        key_c[i] = s[LFSR_W-1];
        s = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? POLY23 : '0);
      end else begin
        key_c[i] = s[15];
        s = LFSR_W'({s[14:0], 1'b0} ^ (s[15] ? POLY16 : 16'h0000));
      end
    end
    if (reload)       next_state_c = gen3 ? seed : LFSR_W'(INIT16);
    else if (advance) next_state_c = s;
    else              next_state_c = state;
  end

endmodule

// File: rtl/pcie_scrambler.sv
// Single-lane TX scrambler for 8b/10b and 128b/130b, 4 symbols per beat, 1-clk latency.
module pcie_scrambler
  import pcie_scrambler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              turnOff,
  input  logic              gen3Mode,
  input  logic [SEED_W-1:0] seedValue,
  input  logic              inValid,
  input  logic              inBlockStart,
  input  logic [1:0]        inSyncHeader,
  input  logic [DATA_W-1:0] inData,
  input  logic [SYMS-1:0]   inDataK,
  output logic              outValid,
  output logic [1:0]        outSyncHeader,
  output logic [DATA_W-1:0] outData,
  output logic [SYMS-1:0]   outDataK
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, seed;
  logic [LFSR_W-1:0] lfsr_s0, lfsr_s1, lfsr_s2, lfsr_s3, lfsr_s4;
  logic              init_pending_q, mode_q, reinit;
  logic [1:0]        cnt_q, cnt_start, cnt_nxt, beat_idx;
  blk_state_t        blk_q, blk_start, blk_nxt, blk_dec, blk_cur;
  sym_ctl_t [SYMS-1:0]           ctl;
  logic [SYMS-1:0][SYM_W-1:0]    key;
  logic [SYM_W-1:0]  sym;
  logic [DATA_W-1:0] data_c;
  logic              unused_seed_msb;

  assign seed            = seedValue[LFSR_W-1:0];
  assign unused_seed_msb = seedValue[SEED_W-1];

  // Start-of-beat context: first clock after reset or a mode change restarts from the mode's init
  always_comb begin
    reinit    = init_pending_q | (mode_q != gen3Mode);
    lfsr_s0   = reinit ? (gen3Mode ? seed : LFSR_W'(INIT16)) : lfsr_q;
    cnt_start = reinit ? 2'd0 : cnt_q;
    blk_start = reinit ? BLK_DATA : blk_q;
    beat_idx  = inBlockStart ? 2'd0 : cnt_start;
    blk_dec   = BLK_DATA;
    if (inSyncHeader == SH_OS) begin
      case (inData[SYM_W-1:0])
        EIEOS_SYM: blk_dec = BLK_OS_EIEOS;
        SKPOS_SYM: blk_dec = BLK_OS_SKP;
        default:   blk_dec = BLK_OS_GEN;
      endcase
    end
    blk_cur = (gen3Mode && inBlockStart) ? blk_dec : blk_start;
  end

  // Per-symbol scramble/advance/reload decisions, applied in symbol order
  always_comb begin
    ctl    = '0;
    sym    = '0;
    data_c = '0;
    for (int i = 0; i < SYMS; i++) begin
      sym = inData[i*SYM_W +: SYM_W];
      ctl[i].scramble = 1'b1;
      ctl[i].advance  = 1'b1;
      ctl[i].reload   = 1'b0;
      if (!gen3Mode) begin
        if (inDataK[i]) begin
          ctl[i].scramble = 1'b0;
          if (sym == COM_SYM)      ctl[i].reload  = 1'b1;
          else if (sym == SKP_SYM) ctl[i].advance = 1'b0;
        end
      end else begin
        case (blk_cur)
          BLK_OS_EIEOS: begin
            ctl[i].scramble = 1'b0;
            ctl[i].reload   = (beat_idx == 2'd3) && (i == SYMS - 1);
          end
          BLK_OS_SKP: begin
            ctl[i].scramble = 1'b0;
            ctl[i].advance  = 1'b0;
          end
          BLK_OS_GEN: ctl[i].scramble = !((beat_idx == 2'd0) && (i == 0));
          default: ;
        endcase
      end
      data_c[i*SYM_W +: SYM_W] = sym ^ ((ctl[i].scramble && !turnOff) ? key[i] : '0);
    end
  end

  pcie_scr_lfsr_step u_step0 (.state(lfsr_s0), .gen3(gen3Mode), .advance(ctl[0].advance),
    .reload(ctl[0].reload), .seed(seed), .next_state_c(lfsr_s1), .key_c(key[0]));
  pcie_scr_lfsr_step u_step1 (.state(lfsr_s1), .gen3(gen3Mode), .advance(ctl[1].advance),
    .reload(ctl[1].reload), .seed(seed), .next_state_c(lfsr_s2), .key_c(key[1]));
  pcie_scr_lfsr_step u_step2 (.state(lfsr_s2), .gen3(gen3Mode), .advance(ctl[2].advance),
    .reload(ctl[2].reload), .seed(seed), .next_state_c(lfsr_s3), .key_c(key[2]));
  pcie_scr_lfsr_step u_step3 (.state(lfsr_s3), .gen3(gen3Mode), .advance(ctl[3].advance),
    .reload(ctl[3].reload), .seed(seed), .next_state_c(lfsr_s4), .key_c(key[3]));

  // Next LFSR, beat counter and block state; everything holds on idle beats
  always_comb begin
    lfsr_nxt = lfsr_s0;
    cnt_nxt  = cnt_start;
    blk_nxt  = blk_start;
    if (inValid) begin
      lfsr_nxt = lfsr_s4;
      if (gen3Mode) begin
        cnt_nxt = inBlockStart ? 2'd1 : 2'(cnt_start + 2'd1);
        if (inBlockStart) blk_nxt = blk_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q         <= LFSR_W'(INIT16);
      cnt_q          <= 2'd0;
      blk_q          <= BLK_DATA;
      init_pending_q <= 1'b1;
      mode_q         <= 1'b0;
      outValid       <= 1'b0;
      outSyncHeader  <= 2'b00;
      outData        <= '0;
      outDataK       <= '0;
    end else begin
      lfsr_q         <= lfsr_nxt;
      cnt_q          <= cnt_nxt;
      blk_q          <= blk_nxt;
      init_pending_q <= 1'b0;
      mode_q         <= gen3Mode;
      outValid       <= inValid;
      outSyncHeader  <= inSyncHeader;
      outData        <= data_c;
      outDataK       <= inDataK;
    end
  end

endmodule

// File: tb/tb_pcie_scrambler.sv
// Scoreboard bench for pcie_scrambler: Gen1 COM/SKP rules, Gen3 block types, reset and turnOff.
module tb_pcie_scrambler;

  logic        clk = 1'b0;
  logic        reset, turnOff, gen3Mode, inValid, inBlockStart;
  logic [23:0] seedValue;
  logic [1:0]  inSyncHeader;
  logic [31:0] inData;
  logic [3:0]  inDataK;
  logic        outValid;
  logic [1:0]  outSyncHeader;
  logic [31:0] outData;
  logic [3:0]  outDataK;

  typedef struct packed {
    logic        valid;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic [3:0]  k;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m16;
  logic [22:0] m23;

  pcie_scrambler dut (
    .clk(clk), .reset(reset), .turnOff(turnOff), .gen3Mode(gen3Mode),
    .seedValue(seedValue), .inValid(inValid), .inBlockStart(inBlockStart),
    .inSyncHeader(inSyncHeader), .inData(inData), .inDataK(inDataK),
    .outValid(outValid), .outSyncHeader(outSyncHeader), .outData(outData),
    .outDataK(outDataK)
  );

  always #5 clk = ~clk;

  // Reference LFSRs: output bit is the MSB, then shift left with feedback
  task automatic key16(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[i] = m16[15];
      m16  = (m16 << 1) ^ (b[i] ? 16'h0039 : 16'h0000);
    end
  endtask

  task automatic key23(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[i] = m23[22];
      m23  = (m23 << 1) ^ (b[i] ? 23'h210125 : 23'h000000);
    end
  endtask

  // kind: 0 data, 1 generic OS, 2 EIEOS, 3 SKP OS
  task automatic model_g3(input int kind, input int b, input logic off,
                          input logic [31:0] d, output logic [31:0] x);
    logic [7:0] kb, s;
    for (int i = 0; i < 4; i++) begin
      s = d[i*8 +: 8];
      if (kind == 3) x[i*8 +: 8] = s;
      else begin
        key23(kb);
        if (off || kind == 2 || (kind == 1 && b == 0 && i == 0)) x[i*8 +: 8] = s;
        else x[i*8 +: 8] = s ^ kb;
      end
    end
    if (kind == 2 && b == 3) m23 = seedValue[22:0];
  endtask

  function automatic logic [31:0] make_beat(input int kind, input int b);
    logic [31:0] d;
    d = $urandom();
    if (kind == 2) d = 32'hFF00FF00;
    else if (kind == 3 && b == 0) d = 32'hAAAAAAAA;
    else if (kind == 1 && b == 0) d[7:0] = 8'h1E;
    return d;
  endfunction

  task automatic drive(input logic v, input logic st, input logic [1:0] h,
                       input logic [31:0] d, input logic [3:0] k, input logic [31:0] xd);
    exp_t x;
    inValid = v; inBlockStart = st; inSyncHeader = h; inData = d; inDataK = k;
    x.valid = v; x.hdr = h; x.data = xd; x.k = k;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; turnOff = 1'b0; gen3Mode = 1'b0; seedValue = 24'h1DBFBC;
    inValid = 1'b1; inBlockStart = 1'b1; inSyncHeader = 2'b10;
    inData = 32'hDEADBEEF; inDataK = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", outValid); end
    if (outSyncHeader !== 2'b00) begin failures++; $display("FAIL reset_hdr got=%b want=00", outSyncHeader); end
    if (outData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", outData); end
    if (outDataK !== 4'h0) begin failures++; $display("FAIL reset_k got=%h want=0", outDataK); end
    reset = 1'b1;
  endtask

  task automatic test_gen1_com();
    logic [31:0] d, x;
    logic [7:0]  kb;
    m16 = 16'hFFFF;
    for (int n = 0; n < 3; n++) key16(kb);
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin d = 32'h000000BC; x = 32'hC017FFBC; end
      else begin
        d = (n == 1) ? 32'h0 : $urandom();
        for (int i = 0; i < 4; i++) begin key16(kb); x[i*8 +: 8] = d[i*8 +: 8] ^ kb; end
      end
      drive(1'b1, 1'b0, 2'b00, d, (n == 0) ? 4'b0001 : 4'b0000, x);
      e = sb.pop_front();
      checks++;
      if (outValid !== e.valid || outDataK !== e.k || outData !== e.data) begin
        failures++;
        $display("FAIL gen1_com beat%0d got v=%b d=%h k=%h want v=%b d=%h k=%h",
                 n, outValid, outData, outDataK, e.valid, e.data, e.k);
      end
    end
  endtask

  task automatic test_gen1_skp();
    logic [31:0] d [4];
    logic [3:0]  k [4];
    logic [31:0] x [4];
    logic [7:0]  kb;
    d[0] = 32'h001C1CBC; k[0] = 4'b0111; x[0] = 32'hFF1C1CBC;
    m16 = 16'hFFFF; key16(kb);
    d[1] = 32'h12345678; k[1] = 4'b0000; x[1] = 32'h0;
    d[2] = 32'h0;        k[2] = 4'b0000;
    for (int i = 0; i < 4; i++) begin key16(kb); x[2][i*8 +: 8] = kb; end
    key16(kb);
    d[3] = 32'h00BC1C00; k[3] = 4'b0110; x[3] = {8'hFF, 8'hBC, 8'h1C, kb};
    for (int n = 0; n < 4; n++) begin
      drive(n != 1, 1'b0, 2'b00, d[n], k[n], x[n]);
      e = sb.pop_front();
      checks++;
      if (outValid !== e.valid || outDataK !== e.k || (e.valid && outData !== e.data)) begin
        failures++;
        $display("FAIL gen1_skp beat%0d got v=%b d=%h k=%h want v=%b d=%h k=%h",
                 n, outValid, outData, outDataK, e.valid, e.data, e.k);
      end
    end
  endtask

  task automatic test_gen3_data();
    logic [31:0] d, x;
    gen3Mode = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL g3_idle got v=%b want v=0", outValid); end
    m23 = seedValue[22:0];
    for (int blk = 0; blk < 2; blk++)
      for (int b = 0; b < 4; b++) begin
        d = (blk == 0) ? 32'h0 : make_beat(0, b);
        model_g3(0, b, 1'b0, d, x);
        drive(1'b1, b == 0, 2'b10, d, 4'h0, x);
        e = sb.pop_front();
        checks++;
        if (outValid !== e.valid || outSyncHeader !== e.hdr || outData !== e.data) begin
          failures++;
          $display("FAIL g3_data blk%0d beat%0d got v=%b h=%b d=%h want v=%b h=%b d=%h descr=%h",
                   blk, b, outValid, outSyncHeader, outData, e.valid, e.hdr, e.data, outData ^ e.data ^ d);
        end
      end
  endtask

  task automatic run_blocks(input string name, input int kinds [5], input int nblk, input int off_blk);
    logic [31:0] d, x;
    logic [1:0]  h;
    for (int blk = 0; blk < nblk; blk++) begin
      turnOff = (blk == off_blk);
      for (int b = 0; b < 4; b++) begin
        d = make_beat(kinds[blk], b);
        h = (kinds[blk] == 0) ? 2'b10 : 2'b01;
        model_g3(kinds[blk], b, turnOff, d, x);
        drive(1'b1, b == 0, h, d, 4'h0, x);
        e = sb.pop_front();
        checks++;
        if (outValid !== e.valid || outSyncHeader !== e.hdr || outData !== e.data) begin
          failures++;
          $display("FAIL %s blk%0d beat%0d got v=%b h=%b d=%h want v=%b h=%b d=%h",
                   name, blk, b, outValid, outSyncHeader, outData, e.valid, e.hdr, e.data);
        end
      end
    end
    turnOff = 1'b0;
  endtask

  task automatic test_gen3_eieos();
    int kinds [5] = '{2, 0, 0, 0, 0};
    run_blocks("g3_eieos", kinds, 2, -1);
  endtask

  task automatic test_gen3_skp();
    int kinds [5] = '{0, 3, 0, 1, 0};
    run_blocks("g3_skp_os", kinds, 5, -1);
  endtask

  task automatic test_reset_turnoff();
    logic [31:0] x;
    int kinds [5] = '{0, 0, 0, 0, 0};
    drive(1'b1, 1'b1, 2'b10, 32'h55AA55AA, 4'h0, 32'h0);
    void'(sb.pop_front());
    reset = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h0 || outSyncHeader !== 2'b00 || outDataK !== 4'h0) begin
      failures++;
      $display("FAIL midblock_reset got v=%b h=%b d=%h k=%h want all zero", outValid, outSyncHeader, outData, outDataK);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h0) begin
      failures++;
      $display("FAIL held_reset got v=%b d=%h want v=0 d=0", outValid, outData);
    end
    reset = 1'b1;
    m23 = seedValue[22:0];
    run_blocks("g3_turnoff", kinds, 3, 1);
    gen3Mode = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 32'h0, 4'h0, 32'h14C017FF);
    e = sb.pop_front();
    checks++;
    x = e.data;
    if (outValid !== 1'b1 || outData !== x) begin
      failures++;
      $display("FAIL mode_switch_gen1 got v=%b d=%h want v=1 d=%h", outValid, outData, x);
    end
  endtask

  initial begin
    test_reset();
    test_gen1_com();
    test_gen1_skp();
    test_gen3_data();
    test_gen3_eieos();
    test_gen3_skp();
    test_reset_turnoff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_scrambler.md
# pcie_scrambler

Transmit-side PCIe PHY scrambler for one lane. It takes 32-bit PIPE-format symbol beats from the TX LTSSM/framing logic and XORs non-control symbols with the lane LFSR sequence. It supports both 8b/10b (Gen1/2, 16-bit LFSR) and 128b/130b (Gen3+, 23-bit LFSR) rules. It sits between TX framing and the PIPE TX interface, and mirrors the lane descrambler on the receive side.

## Interface
- No parameters; datapath fixed at 4 symbols per beat, symbol 0 in bits [7:0] and transmitted first.
- clk  in  1  PIPE PCLK.
- reset  in  1  asynchronous, active-low.
- turnOff  in  1  scrambling disabled; data passes through and the LFSR still tracks.
- gen3Mode  in  1  0: 8b/10b rules, 1: 128b/130b rules.
- seedValue  in  24  Gen3 lane seed; bits [22:0] used.
- inValid  in  1  beat valid.
- inBlockStart  in  1  Gen3 only; first beat of a 16-symbol block.
- inSyncHeader  in  2  Gen3 block type, sampled with inBlockStart: 2'b10 data, 2'b01 ordered set.
- inData  in  32  symbols.
- inDataK  in  4  per-symbol K flag (Gen1/2).
- outValid  out  1  registered inValid.
- outSyncHeader  out  2  registered inSyncHeader.
- outData  out  32  scrambled symbols.
- outDataK  out  4  registered inDataK.

## Operation
- Gen1/2 LFSR: polynomial x^16+x^5+x^4+x^3+1, init 16'hFFFF, advanced 8 steps per symbol. Symbols are processed serially 0→3 within a beat.
  - COM (K=1, 8'hBC): sent unscrambled; LFSR reloaded to 16'hFFFF for the next symbol.
  - SKP (K=1, 8'h1C): unscrambled; LFSR not advanced.
  - Other K symbols: unscrambled; LFSR advanced.
  - D symbols: XOR with the LFSR output byte; LFSR advanced.
- Gen3 LFSR: polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, init seedValue[22:0], advanced 8 steps per symbol. inDataK is ignored.
  - Data block: all 16 symbols scrambled.
  - Ordered set: block type is decoded from symbol 0 of the inBlockStart beat and held in a 2-bit block-state register for the 4 beats.
    - EIEOS (8'h00): unscrambled, LFSR advanced; LFSR reloaded to seed after the block's 4th beat.
    - SKP OS (8'hAA): unscrambled, LFSR frozen for the whole block.
    - Other OS: symbol 0 unscrambled; symbols 1–15 scrambled; LFSR advanced on every symbol.
- Block beat counter (2 bits): loads 1 on inBlockStart and wraps 3→0. If inBlockStart arrives mid-block, restart the block and keep the LFSR as-is.
- inValid=0: LFSR, counter, and block state hold; outputs still register (outValid=0).
- turnOff=1: outData=inData, but the LFSR follows the same advance/reset rules so it stays aligned when turnOff drops.
- gen3Mode change: LFSR reloads to the new mode's init value on the next clock, and the counter clears.

## Timing
- Latency is 1 clk for all outputs, which register together.
- Reset values: outValid=0, outSyncHeader=0, outData=0, outDataK=0, LFSR16=16'hFFFF, LFSR23=seedValue[22:0] (loaded on the first clock after reset release), counter=0.
- LFSR state after a beat is the result of 0–4 symbol steps, computed combinationally in one cycle.
- Simultaneous COM and SKP in one beat: apply in symbol order.
- EIEOS reload and a new inBlockStart on the same clock: the reload is applied first, and the new block uses the seed.

## Structure
- Shared package: both polynomials, the 16'hFFFF init, COM/SKP/EIEOS/SKPOS codes, sync header encodings, and the block-state enum (DATA, OS_GEN, OS_EIEOS, OS_SKP).
- One sub-module, pcie_scr_lfsr_step: combinational single-symbol step taking LFSR state, mode, advance and reload inputs, and returning the next state and scramble byte; instantiated 4× in a chain.

## Test plan
- Gen1: COM, then D bytes 8'h00 ×2 → outData symbols 8'hBC, 8'hFF, 8'h17 (K preserved), 1 clk later.
- Gen1: COM, SKP, SKP, D 8'h00 → SKPs unchanged; D byte = 8'hFF (SKP does not advance).
- Gen3: seed 24'h1DBFBC, a data block of zeros, then chain into the lane descrambler with the same seed → original zeros recovered; outSyncHeader 2'b10.
- Gen3: EIEOS block (zero-ended) followed by a data block → EIEOS passes unmodified; the data block scrambles identically to a fresh post-reset block.
- Gen3: SKP OS inserted between two data blocks → SKP unmodified; the second data block matches a reference stream generated without the SKP.
- Assert reset mid-block, and toggle turnOff for 4 beats → outputs zero during reset; during turnOff, outData = inData; after turnOff drops, scrambling is continuous with a never-disabled model.
